// File: rtl/ped_pkg.sv
// Shared types and timing constants for the pedestrian request conditioner.
package ped_pkg;

    localparam int unsigned CLK_HZ      = 12_000_000;
    localparam int unsigned DEBOUNCE_MS = 20;

    // 20 ms at 12 MHz = 240000 samples.
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

    typedef enum logic [1:0] {
        StStableLo = 2'd0,
        StWaitHi   = 2'd1,
        StStableHi = 2'd2,
        StWaitLo   = 2'd3
    } deb_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Synchronises and debounces the raw button pin, producing a clean level and a
// one-cycle pulse on each accepted press.
module btn_debounce
    import ped_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit          BTN_ACTIVE_LOW  = 1'b0,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse
);

    // The counter only ever holds 1..DEBOUNCE_CYCLES-1: the sample that would
    // reach DEBOUNCE_CYCLES moves the FSM to a stable state and clears it.
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    logic             btn_in;
    logic             s1_q, s2_q;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;

    assign btn_in = btn_raw ^ BTN_ACTIVE_LOW;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= btn_in;
            s2_q <= s1_q;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StStableLo;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    // Next state: any sample disagreeing with the pending level restarts the wait.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StStableLo: begin
                cnt_d = '0;
                if (s2_q) begin
                    state_d = StWaitHi;
                    cnt_d   = CntOne;
                end
            end
            StWaitHi: begin
                if (!s2_q) begin
                    state_d = StStableLo;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StStableHi;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StStableHi: begin
                cnt_d = '0;
                if (!s2_q) begin
                    state_d = StWaitLo;
                    cnt_d   = CntOne;
                end
            end
            StWaitLo: begin
                if (s2_q) begin
                    state_d = StStableHi;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StStableLo;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StStableLo;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the next state so the level registers with the transition.
    always_comb begin
        level_d = (state_d == StStableHi) || (state_d == StWaitLo);
        pulse_d = level_d && !level_q;
    end

    assign btn_level   = level_q;
    assign press_pulse = pulse_q;

endmodule

// File: rtl/ped_request_conditioner.sv
// Turns debounced button presses into a single held crossing request that the
// traffic controller clears with an acknowledge pulse.
module ped_request_conditioner
    import ped_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter bit          BTN_ACTIVE_LOW  = 1'b0,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic walk_active,
    input  logic req_ack,
    output logic btn_level,
    output logic press_pulse,
    output logic req_pending,
    output logic press_ignored
);

    logic pulse;
    logic req_q, req_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW),
        .CNT_W           (CNT_W)
    ) u_btn_debounce (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .press_pulse (pulse)
    );

    // Request latch register.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= 1'b0;
        end else begin
            req_q <= req_d;
        end
    end

    // Ack has priority over a new press; a press only sets an idle latch.
    always_comb begin
        req_d = req_q;
        if (req_ack) begin
            req_d = 1'b0;
        end else if (pulse && !walk_active && !req_q) begin
            req_d = 1'b1;
        end
    end

    // A press that cannot set the latch is reported as discarded.
    always_comb begin
        press_ignored = pulse && (walk_active || req_q || req_ack);
    end

    assign press_pulse = pulse;
    assign req_pending = req_q;

endmodule

// File: tb/tb_ped_request_conditioner.sv
// Randomised bench for ped_request_conditioner with a window-based reference model.
module tb_ped_request_conditioner;

    localparam int unsigned D = 8;

    logic clk = 1'b0;
    logic rst;
    logic btn_raw;
    logic walk_active;
    logic req_ack;
    logic btn_level;
    logic press_pulse;
    logic req_pending;
    logic press_ignored;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic m_s1, m_s2, m_level, m_pulse, m_req;
    logic seen[$];

    always #5 clk = ~clk;

    ped_request_conditioner #(
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_raw       (btn_raw),
        .walk_active   (walk_active),
        .req_ack       (req_ack),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .req_pending   (req_pending),
        .press_ignored (press_ignored)
    );

    task automatic check_eq(input string tag, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    // Level flips once the last D samples seen after synchronisation all
    // disagree with it; history is forgotten on every flip and on reset.
    task automatic model_step();
        logic samp;
        logic flip;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_pulse = 0; m_req = 0;
            seen.delete();
        end else begin
            if (req_ack) m_req = 0;
            else if (m_pulse && !walk_active && !m_req) m_req = 1;
            samp = m_s2;
            m_s2 = m_s1;
            m_s1 = btn_raw;
            seen.push_back(samp);
            if (seen.size() > D) void'(seen.pop_front());
            flip = (seen.size() == D);
            foreach (seen[i]) if (seen[i] == m_level) flip = 0;
            m_pulse = flip && !m_level;
            if (flip) begin
                m_level = !m_level;
                seen.delete();
            end
        end
    endtask

    task automatic check_all();
        check_eq("btn_level", btn_level, m_level);
        check_eq("press_pulse", press_pulse, m_pulse);
        check_eq("req_pending", req_pending, m_req);
        check_eq("press_ignored", press_ignored,
                 m_pulse && (walk_active || m_req || req_ack));
    endtask

    // One clock: drive on the falling edge, advance model on the rising edge,
    // compare just after it.
    task automatic step(input logic b, input logic w, input logic a, input logic r);
        @(negedge clk);
        btn_raw = b; walk_active = w; req_ack = a; rst = r;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        logic lvl;
        logic w;
        btn_raw = 0; walk_active = 0; req_ack = 0; rst = 1;

        // Reset state.
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check_eq("rst_level", btn_level, 1'b0);
        check_eq("rst_pulse", press_pulse, 1'b0);
        check_eq("rst_req", req_pending, 1'b0);
        check_eq("rst_ign", press_ignored, 1'b0);

        // Clean press with absolute latency: edge i is the i-th edge sampling high.
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 0);
            check_eq("lat_level", btn_level, 1'(i >= int'(D) + 1));
            check_eq("lat_pulse", press_pulse, 1'(i == int'(D) + 1));
            check_eq("lat_req", req_pending, 1'(i >= int'(D) + 2));
        end
        // Release: level drops after edge D+1, no pulse.
        for (int i = 0; i < 14; i++) begin
            step(0, 0, 0, 0);
            check_eq("rel_level", btn_level, 1'(i < int'(D) + 1));
            check_eq("rel_pulse", press_pulse, 1'b0);
        end
        // Ack clears the request one cycle later.
        step(0, 0, 1, 0);
        check_eq("ack_clear", req_pending, 1'b0);

        // Random phases of clean holds, bounces, lockout, acks and resets.
        lvl = 0;
        for (int p = 0; p < 150; p++) begin
            int mode;
            int len;
            int per;
            mode = $urandom_range(0, 3);
            w = ($urandom_range(0, 3) == 0);
            len = $urandom_range(1, 26);
            per = $urandom_range(1, 4);
            for (int c = 0; c < len; c++) begin
                logic a;
                logic r;
                if (mode == 1 && (c % per) == 0) lvl = !lvl;
                else if (mode == 2) lvl = 0;
                else if (mode == 3) lvl = 1;
                a = ($urandom_range(0, 11) == 0);
                r = ($urandom_range(0, 299) == 0);
                step(lvl, w, a, r);
            end
        end

        // Drain with the button released.
        for (int i = 0; i < 2 * (int'(D) + 2); i++) step(0, 0, 0, 0);
        check_eq("end_level", btn_level, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus process stalls.
    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish, got running expected done");
        $fatal(1);
    end

endmodule
